// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared joint-mode, colour and sequencer-state definitions for the arm controller
package arm_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;

    localparam logic [7:0] BYTE_R = 8'h52;
    localparam logic [7:0] BYTE_G = 8'h47;
    localparam logic [7:0] BYTE_B = 8'h42;

    localparam logic [1:0] COL_NONE = 2'b00;
    localparam logic [1:0] COL_R    = 2'b01;
    localparam logic [1:0] COL_G    = 2'b10;
    localparam logic [1:0] COL_B    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_OBJ, S_REACH, S_GRIP, S_LIFT, S_SWING, S_RELEASE, S_RETURN, S_DONE
    } seq_state_t;

    // Unrecognised bytes map to COL_NONE, which is how they get ignored
    function automatic logic [1:0] colour_code(input logic [7:0] b);
        return b == BYTE_R ? COL_R : b == BYTE_G ? COL_G : b == BYTE_B ? COL_B : COL_NONE;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler emitting a 1-cycle tick every TICK_DIV clocks
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick_o = cnt_q == W'(TICK_DIV - 1);

    // Wrap the prescaler on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/sort_sequencer.sv
// sort_sequencer: colour-driven pick-and-place sequencer with manual/automatic joint-mode mux
module sort_sequencer
    import arm_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int PRESENT_MS = 200,
    parameter int WAIT_MS    = 5000,
    parameter int REACH_MS   = 800,
    parameter int GRIP_MS    = 500,
    parameter int SWING_R_MS = 400,
    parameter int SWING_G_MS = 800,
    parameter int SWING_B_MS = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       manual_sel,
    input  logic [1:0] man_mode1,
    input  logic [1:0] man_mode2,
    input  logic [1:0] man_mode3,
    input  logic [1:0] man_mode4,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       obj_near,
    output logic [1:0] mode1,
    output logic [1:0] mode2,
    output logic [1:0] mode3,
    output logic [1:0] mode4,
    output logic       busy,
    output logic [1:0] colour,
    output logic       fault,
    output logic       overrun
);

    seq_state_t state_q, state_d;
    logic        tick;
    logic [15:0] step_q, pres_q, swing_len, phase_len;
    logic        pend_valid_q, fault_q, overrun_q, acc, consume, phase_end, pres_hit, timeout;
    logic [1:0]  pend_col_q, colour_q, rx_code;
    logic [1:0]  mode_q [4];
    logic [1:0]  fsm_mode [4];
    logic [1:0]  man_mode [4];

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst), .tick_o(tick));

    assign man_mode  = '{man_mode1, man_mode2, man_mode3, man_mode4};
    assign rx_code   = colour_code(rx_data);
    assign acc       = rx_valid && !manual_sel && rx_code != COL_NONE;
    assign consume   = pend_valid_q && (state_q == S_IDLE || state_q == S_DONE);
    assign swing_len = colour_q == COL_R ? 16'(SWING_R_MS) : colour_q == COL_G ? 16'(SWING_G_MS) : 16'(SWING_B_MS);
    assign phase_len = state_q == S_WAIT_OBJ ? 16'(WAIT_MS) :
                       (state_q == S_REACH || state_q == S_LIFT) ? 16'(REACH_MS) :
                       (state_q == S_GRIP || state_q == S_RELEASE) ? 16'(GRIP_MS) : swing_len;
    assign phase_end = tick && step_q == phase_len - 16'd1;
    assign pres_hit  = tick && obj_near && pres_q == 16'(PRESENT_MS - 1);
    assign timeout   = state_q == S_WAIT_OBJ && !pres_hit && phase_end && !manual_sel;

    assign {mode1, mode2, mode3, mode4} = {mode_q[0], mode_q[1], mode_q[2], mode_q[3]};
    assign busy    = state_q != S_IDLE;
    assign colour  = colour_q;
    assign fault   = fault_q;
    assign overrun = overrun_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state: timed phases advance on phase_end; manual mode always forces IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pend_valid_q || acc) state_d = S_WAIT_OBJ;
            S_WAIT_OBJ: state_d = pres_hit ? S_REACH : phase_end ? S_IDLE : S_WAIT_OBJ;
            S_REACH:    if (phase_end) state_d = S_GRIP;
            S_GRIP:     if (phase_end) state_d = S_LIFT;
            S_LIFT:     if (phase_end) state_d = S_SWING;
            S_SWING:    if (phase_end) state_d = S_RELEASE;
            S_RELEASE:  if (phase_end) state_d = S_RETURN;
            S_RETURN:   if (phase_end) state_d = S_DONE;
            S_DONE:     state_d = pend_valid_q ? S_WAIT_OBJ : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (manual_sel) state_d = S_IDLE;
    end

    // Joint modes per state; joints not driven by a state hold
    always_comb begin
        fsm_mode[0] = state_q == S_SWING ? MODE_FWD : state_q == S_RETURN ? MODE_REV : MODE_HOLD;
        fsm_mode[1] = state_q == S_REACH ? MODE_FWD : state_q == S_LIFT ? MODE_REV : MODE_HOLD;
        fsm_mode[2] = MODE_HOLD;
        fsm_mode[3] = state_q == S_GRIP ? MODE_FWD : state_q == S_RELEASE ? MODE_REV : MODE_HOLD;
    end

    // Counters, pending buffer, job colour, fault/overrun flags and the registered mode mux
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q       <= '0;
            pres_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_col_q   <= COL_NONE;
            colour_q     <= COL_NONE;
            fault_q      <= 1'b0;
            overrun_q    <= 1'b0;
            mode_q       <= '{default: MODE_HOLD};
        end else begin
            step_q    <= state_d != state_q ? '0 : step_q + 16'(tick);
            pres_q    <= (state_d != state_q || !obj_near) ? '0 : pres_q + 16'(tick);
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++)
                mode_q[i] <= !manual_sel ? fsm_mode[i] : man_mode[i] == 2'b11 ? MODE_HOLD : man_mode[i];
            if (manual_sel) begin
                pend_valid_q <= 1'b0;
                colour_q     <= COL_NONE;
            end else begin
                if (acc && (state_q != S_IDLE || pend_valid_q)) begin
                    if (!pend_valid_q || consume) {pend_valid_q, pend_col_q} <= {1'b1, rx_code};
                    else overrun_q <= 1'b1;
                end else if (consume) pend_valid_q <= 1'b0;
                if (consume) colour_q <= pend_col_q;
                else if (state_q == S_IDLE && acc) colour_q <= rx_code;
                else if (state_q == S_DONE || timeout) colour_q <= COL_NONE;
                if (timeout) fault_q <= 1'b1;
                else if (acc) fault_q <= 1'b0;
            end
        end
    end

endmodule
